// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Bit-counter width; never below 1 so a 2-bit datapath still has a counter.
   function automatic int unsigned cnt_w(input int unsigned width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/half_subtractor.sv
// Combinational one-bit half subtractor: diff = a ^ b, borrow = ~a & b.
module half_subtractor (
   input  logic inbit_0,
   input  logic inbit_1,
   output logic diff,
   output logic borrow_out
);

   assign diff       = inbit_0 ^ inbit_1;
   assign borrow_out = ~inbit_0 & inbit_1;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (minuend - subtrahend), LSB first, one bit per clock,
// with a start/done handshake and registered result flags.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] minuend,
   input  logic [WIDTH-1:0] subtrahend,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] difference,
   output logic             borrow_out,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned     CNT_W = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-2:0] r_sr_q, r_sr_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;

   logic             hs0_diff, hs0_brw, bit_d, hs1_brw, brw_next;
   logic [WIDTH-1:0] res_next;

   // Full-subtract cell: two half subtractors chained through the borrow register.
   half_subtractor u_hs0 (
      .inbit_0    (a_sr_q[0]),
      .inbit_1    (b_sr_q[0]),
      .diff       (hs0_diff),
      .borrow_out (hs0_brw)
   );

   half_subtractor u_hs1 (
      .inbit_0    (hs0_diff),
      .inbit_1    (brw_q),
      .diff       (bit_d),
      .borrow_out (hs1_brw)
   );

   assign brw_next = hs0_brw | hs1_brw;
   assign res_next = {bit_d, r_sr_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         r_sr_q  <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         brw_q   <= brw_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         r_sr_q  <= r_sr_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      brw_d   = brw_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      r_sr_d  = r_sr_q;
      a_msb_d = a_msb_q;
      b_msb_d = b_msb_q;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_sr_d  = minuend;
               b_sr_d  = subtrahend;
               a_msb_d = minuend[WIDTH-1];
               b_msb_d = subtrahend[WIDTH-1];
               brw_d   = 1'b0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
            r_sr_d = res_next[WIDTH-1:1];
            brw_d  = brw_next;
            cnt_d  = cnt_q + CNT_W'(1);
            busy_d = 1'b1;
            // Final bit: publish the result and flags; overflow uses the captured MSBs.
            if (cnt_q == LAST) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               diff_d  = res_next;
               bout_d  = brw_next;
               ovf_d   = (a_msb_q ^ b_msb_q) & (bit_d ^ a_msb_q);
               zero_d  = (res_next == '0);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign difference = diff_q;
   assign borrow_out = bout_q;
   assign overflow   = ovf_q;
   assign zero       = zero_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor, the inverse arithmetic counterpart to the existing half_adder datapath cell.
- Computes difference = minuend - subtrahend, LSB first, one bit per clock.
- Uses a single borrow flip-flop and a half_subtractor cell pair.
- Forms the SUB path of the project ALU where area matters more than latency. Start/done handshake to the ALU sequencer.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- minuend  input  WIDTH  operand A; captured on accepted start
- subtrahend  input  WIDTH  operand B; captured on accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse; result outputs valid from this cycle on
- difference  output  WIDTH  A - B modulo 2^WIDTH
- borrow_out  output  1  1 when A < B (unsigned)
- overflow  output  1  signed overflow: A[MSB]!=B[MSB] and difference[MSB]!=A[MSB]
- zero  output  1  difference == 0

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE, counter=0, borrow register=0, shift registers=0.
  - Outputs busy=0, done=0, difference=0, borrow_out=0, overflow=0, zero=0.
  - An in-flight operation is discarded; no done is produced for it.
- FSM states are IDLE, RUN and DONE.
- IDLE: busy=0.
  - start=1 at a rising edge captures A into shift reg a_sr and B into b_sr.
  - Same edge: borrow register=0, counter=0, state->RUN.
- RUN: busy=1. Each edge:
  - d = a_sr[0]^b_sr[0]^borrow.
  - next borrow = (~a_sr[0]&b_sr[0]) | (~(a_sr[0]^b_sr[0]) & borrow).
  - a_sr, b_sr shift right by one; d shifts into the MSB of the result register.
  - counter increments.
  - When counter==WIDTH-1 on that edge: state->DONE, result outputs update, borrow_out=final borrow.
  - start is ignored in RUN; operand inputs may change freely.
- DONE: busy=0, done=1 for exactly this one cycle.
  - start=1 here is accepted exactly as in IDLE (back-to-back), state->RUN.
  - Otherwise state->IDLE.
- Latency: done rises exactly WIDTH clocks after the edge that accepted start. A new operation can be accepted every WIDTH+1 clocks.
- Result hold: difference, borrow_out, overflow and zero are registered. They hold their last values until the next completion or reset; they do not toggle during RUN.
- overflow uses the captured MSBs of A and B, stored at accept time, not the live inputs.
- Arithmetic is modulo 2^WIDTH. borrow_out is the unsigned borrow, independent of overflow.

Decomposition:
- Shared header subtractor_defs.vh holds:
  - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - a CNT_W function/macro equal to $clog2(WIDTH).
- One sub-module: half_subtractor (inbit_0, inbit_1 -> diff, borrow_out), combinational, diff=a^b, borrow=~a&b.
- Two half_subtractor instances plus an OR form the per-bit full-subtract cell inside serial_subtractor.

Test Plan (WIDTH=8):
- A=0x05, B=0x03, start one cycle -> done 8 clocks later; difference=0x02, borrow_out=0, overflow=0, zero=0; busy high for exactly 8 cycles.
- A=0x03, B=0x05 -> difference=0xFE, borrow_out=1, overflow=0, zero=0.
- A=0x80, B=0x01 -> difference=0x7F, borrow_out=0, overflow=1. Then A=0x7F, B=0xFF -> difference=0x80, borrow_out=1, overflow=1.
- A=0x5A, B=0x5A -> difference=0x00, zero=1, borrow_out=0. Then start held high through the DONE cycle with A=0x10, B=0x01 -> second op accepted back-to-back; done after 8 more clocks, difference=0x0F.
- start pulsed, then start re-pulsed at RUN cycle 3 with different operands -> ignored; result matches the first operands only; exactly one done pulse.
- rst asserted asynchronously (mid-cycle) at RUN cycle 4 -> all outputs 0 immediately, no done. A following start of A=0xFF, B=0x00 -> difference=0xFF, borrow_out=0.
